// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and
// sticky overrun/framing flags that are cleared by a consumer read.
module uart_rx #(
    parameter int CLK_FREQ = 48000000,
    parameter int BIT_FREQ = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       rd,
    output logic       brk,
    output logic       overrun,
    output logic       ferr,
    output logic [2:0] state_dbg
);

    localparam int DIVISOR = CLK_FREQ / BIT_FREQ;
    localparam int HALF    = DIVISOR / 2;
    localparam int CW      = $clog2(DIVISOR);

    // Consumer handshake: rdy=1 means rx_data holds an unread byte; a cycle
    // with rd=1 and rdy=1 consumes it on that edge. rd while rdy=0 is ignored.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t          state;
    state_t          next;
    logic            s1;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tick;
    logic            load_half;
    logic            load_div;
    logic            sample_bit;
    logic            deliver;
    logic            set_break;
    logic            set_ferr;
    logic            clr_break;
    logic            ack;

    assign tick      = (cnt == '0);
    assign ack       = rd && rdy;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= rx;
            rxs <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next       = state;
        load_half  = 1'b0;
        load_div   = 1'b0;
        sample_bit = 1'b0;
        deliver    = 1'b0;
        set_break  = 1'b0;
        set_ferr   = 1'b0;
        clr_break  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    next      = START;
                    load_half = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        next = IDLE;
                    end else begin
                        next     = DATA;
                        load_div = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sample_bit = 1'b1;
                    load_div   = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxs) begin
                        deliver = 1'b1;
                        next    = IDLE;
                    end else if (shift == 8'h00) begin
                        set_break = 1'b1;
                        next      = WAIT;
                    end else begin
                        set_ferr = 1'b1;
                        next     = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rxs) begin
                    clr_break = 1'b1;
                    next      = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Every sample reloads the counter, so bit timing never accumulates error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (load_half) begin
                cnt <= CW'(HALF - 1);
            end else if (load_div) begin
                cnt <= CW'(DIVISOR - 1);
            end else if (!tick) begin
                cnt <= cnt - 1'b1;
            end
            if (load_half) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit) begin
                shift[bit_idx] <= rxs;
            end
        end
    end

    // A delivery coinciding with a read wins: the byte stays ready, flags clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
            brk     <= 1'b0;
        end else begin
            if (deliver) begin
                rx_data <= shift;
                rdy     <= 1'b1;
                if (ack) begin
                    overrun <= 1'b0;
                    ferr    <= 1'b0;
                end else if (rdy) begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
                ferr    <= 1'b0;
            end
            if (set_ferr) begin
                ferr <= 1'b1;
            end
            if (set_break) begin
                brk <= 1'b1;
            end else if (clr_break) begin
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=5, HALF=2: good frames, overrun,
// false start, break, framing error, mid-frame reset and read/delivery collision.
module tb_uart_rx;

    localparam logic [7:0] S_IDLE  = 8'd0;
    localparam logic [7:0] S_START = 8'd1;
    localparam logic [7:0] S_WAIT  = 8'd4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rdy;
    logic       rd;
    logic       brk;
    logic       overrun;
    logic       ferr;
    logic [2:0] state_dbg;

    logic [7:0] exp_q[$];
    int         checks;
    int         failures;

    uart_rx #(.CLK_FREQ(16), .BIT_FREQ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .rd        (rd),
        .brk       (brk),
        .overrun   (overrun),
        .ferr      (ferr),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk(tag, rx_data, e);
    endtask

    // drivers: all called at posedge+1 and return at posedge+1
    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, 5);
        for (int i = 0; i < 8; i++) hold(d[i], 5);
        hold(stop, 5);
        rx = 1'b1;
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        rx  = 1'b1;
        rd  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_rdy", {7'd0, rdy}, 8'd0);
        chk("rst_brk", {7'd0, brk}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);
        chk("rst_ferr", {7'd0, ferr}, 8'd0);
        chk("rst_state", {5'd0, state_dbg}, S_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 4);

        // single good frame then read
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        chk("a5_rdy", {7'd0, rdy}, 8'd1);
        chk_data("a5_data");
        chk("a5_ferr", {7'd0, ferr}, 8'd0);
        @(posedge clk);
        #1;
        read_pulse();
        @(negedge clk);
        chk("a5_rd_rdy", {7'd0, rdy}, 8'd0);
        hold(1'b1, 2);

        // overrun
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        chk_data("3c_data");
        chk("3c_ovr", {7'd0, overrun}, 8'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        @(negedge clk);
        chk_data("c3_data");
        chk("c3_rdy", {7'd0, rdy}, 8'd1);
        chk("c3_ovr", {7'd0, overrun}, 8'd1);
        @(posedge clk);
        #1;
        read_pulse();
        @(negedge clk);
        chk("c3_rd_rdy", {7'd0, rdy}, 8'd0);
        chk("c3_rd_ovr", {7'd0, overrun}, 8'd0);
        @(posedge clk);
        #1;

        // false start: one low cycle
        hold(1'b0, 1);
        hold(1'b1, 3);
        @(negedge clk);
        chk("fs_in_start", {5'd0, state_dbg}, S_START);
        @(posedge clk);
        #1;
        hold(1'b1, 6);
        @(negedge clk);
        chk("fs_idle", {5'd0, state_dbg}, S_IDLE);
        chk("fs_rdy", {7'd0, rdy}, 8'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        @(negedge clk);
        chk_data("55_data");
        chk("55_rdy", {7'd0, rdy}, 8'd1);
        @(posedge clk);
        #1;
        read_pulse();
        hold(1'b1, 2);

        // break: 60 low cycles, stop sample at cycle 50
        hold(1'b0, 48);
        @(negedge clk);
        chk("brk_before", {7'd0, brk}, 8'd0);
        @(posedge clk);
        #1;
        hold(1'b0, 6);
        @(negedge clk);
        chk("brk_set", {7'd0, brk}, 8'd1);
        chk("brk_state", {5'd0, state_dbg}, S_WAIT);
        chk("brk_rdy", {7'd0, rdy}, 8'd0);
        chk("brk_data", rx_data, 8'h55);
        chk("brk_ferr", {7'd0, ferr}, 8'd0);
        @(posedge clk);
        #1;
        hold(1'b0, 5);
        hold(1'b1, 2);
        @(negedge clk);
        chk("brk_hold", {7'd0, brk}, 8'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("brk_clear", {7'd0, brk}, 8'd0);
        chk("brk_idle", {5'd0, state_dbg}, S_IDLE);
        @(posedge clk);
        #1;
        hold(1'b1, 2);

        // framing error, then next frame with ferr still sticky
        send_frame(8'h01, 1'b0);
        @(negedge clk);
        chk("fe_ferr", {7'd0, ferr}, 8'd1);
        chk("fe_brk", {7'd0, brk}, 8'd0);
        chk("fe_rdy", {7'd0, rdy}, 8'd0);
        chk("fe_data", rx_data, 8'h55);
        @(posedge clk);
        #1;
        hold(1'b1, 8);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        @(negedge clk);
        chk_data("7e_data");
        chk("7e_rdy", {7'd0, rdy}, 8'd1);
        chk("7e_ferr", {7'd0, ferr}, 8'd1);
        @(posedge clk);
        #1;
        read_pulse();
        @(negedge clk);
        chk("7e_rd_ferr", {7'd0, ferr}, 8'd0);
        chk("7e_rd_rdy", {7'd0, rdy}, 8'd0);
        @(posedge clk);
        #1;
        hold(1'b1, 2);

        // reset during data bit 4 of 0xFF
        hold(1'b0, 5);
        hold(1'b1, 22);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_data", rx_data, 8'h00);
        chk("mr_rdy", {7'd0, rdy}, 8'd0);
        chk("mr_state", {5'd0, state_dbg}, S_IDLE);
        @(posedge clk);
        #1;
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 30);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        @(negedge clk);
        chk_data("81_data");
        chk("81_rdy", {7'd0, rdy}, 8'd1);
        @(posedge clk);
        #1;
        hold(1'b1, 2);

        // framing error while a byte is pending, then delivery colliding with rd
        send_frame(8'h10, 1'b0);
        hold(1'b1, 6);
        @(negedge clk);
        chk("pend_ferr", {7'd0, ferr}, 8'd1);
        chk("pend_data", rx_data, 8'h81);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h42);
        fork
            send_frame(8'h42, 1'b1);
            begin
                repeat (49) @(posedge clk);
                #1;
                rd = 1'b1;
                @(posedge clk);
                #1;
                rd = 1'b0;
            end
        join
        @(negedge clk);
        chk_data("col_data");
        chk("col_rdy", {7'd0, rdy}, 8'd1);
        chk("col_ovr", {7'd0, overrun}, 8'd0);
        chk("col_ferr", {7'd0, ferr}, 8'd0);
        @(posedge clk);
        #1;
        read_pulse();
        @(negedge clk);
        chk("end_rdy", {7'd0, rdy}, 8'd0);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 48000000, clk frequency in Hz.
REQ-002 SHALL have parameter BIT_FREQ, default 115200, line bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  last successfully received byte.
REQ-007 SHALL have port rdy  output  1  rx_data holds an unread byte.
REQ-008 SHALL have port rd  input  1  consumer acknowledge; takes effect only when rdy=1.
REQ-009 SHALL have port break  output  1  line-break condition in progress.
REQ-010 SHALL have port overrun  output  1  sticky; an unread byte was overwritten.
REQ-011 SHALL have port ferr  output  1  sticky; framing error seen since last read.

Function
REQ-012 SHALL compute DIVISOR = CLK_FREQ/BIT_FREQ (integer division) and HALF = DIVISOR/2; DIVISOR < 3 is unsupported.
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT; break is asserted exactly while in WAIT with break cause.
REQ-015 IDLE: first cycle T0 with rxs=0 -> START, with the bit counter loaded so that the start sample falls at T0+HALF.
REQ-016 START: at T0+HALF, if rxs=1 (false start) -> IDLE with no output change; else -> DATA, bit index 0.
REQ-017 DATA: sample rxs at T0+HALF+k*DIVISOR (k=1..8) into bit k-1 of the shift register; after k=8 -> STOP.
REQ-018 STOP: sample at T0+HALF+9*DIVISOR; rxs=1 -> on that edge rx_data<=shift, rdy<=1, -> IDLE.
REQ-019 STOP with rxs=0 and shift=0x00 -> break<=1, -> WAIT; rx_data and rdy unchanged.
REQ-020 STOP with rxs=0 and shift!=0x00 -> ferr<=1, -> WAIT; rx_data and rdy unchanged.
REQ-021 WAIT: remain until rxs=1, then break<=0, -> IDLE; a new start bit is accepted only from IDLE.
REQ-022 Delivery while rdy=1 and rd=0 SHALL overwrite rx_data and set overrun<=1.
REQ-023 rd=1 with rdy=1 SHALL clear rdy, overrun, ferr on the next edge; rd with rdy=0 SHALL have no effect.
REQ-024 Delivery in the same cycle as rd=1 SHALL take priority: rdy stays 1, rx_data updated, overrun not set, overrun and ferr cleared.
REQ-025 Bit-timing counter SHALL reset on each state entry; no drift accumulation across bits within a frame.

Reset
REQ-026 While rst=1: state IDLE, synchronizer flops=1, rx_data=0x00, rdy=0, break=0, overrun=0, ferr=0, counters=0.
REQ-027 rst asserted mid-frame SHALL abandon the frame; after release, the next falling edge on rx starts a fresh frame.

Verification (CLK_FREQ=16, BIT_FREQ=3 -> DIVISOR=5, HALF=2)
REQ-028 Frame 0xA5, valid stop bit -> rdy=1, rx_data=0xA5, ferr=0; then rd pulse -> rdy=0 on the following edge.
REQ-029 Frames 0x3C then 0xC3, no rd -> rx_data=0xC3, rdy=1, overrun=1; rd -> rdy=0, overrun=0.
REQ-030 rx low for 1 cycle then high -> false start, rdy stays 0, state returns to IDLE, next 0x55 frame received correctly.
REQ-031 rx held low for 12 bit times, then high -> break=1 from stop sample until 2 cycles after rx rises, rdy=0, rx_data unchanged.
REQ-032 Frame 0x01 with stop bit 0, rx high 1 bit later -> ferr=1, rdy=0, break=0; next 0x7E frame delivered with ferr still 1 until rd.
REQ-033 rst pulse during data bit 4 of 0xFF -> all outputs 0 during reset; subsequent 0x81 frame -> rx_data=0x81, rdy=1.
